// File: rtl/ahb_rom_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rom_arbiter
//
// Purpose:
//   Two-master AHB-Lite read arbiter sharing one ROM slave whose read data is
//   combinational from its address. Each master's address phase is captured
//   into a pending register and served in a later data phase. A master that
//   is waiting for service is stalled with HREADYx low. Arbitration is either
//   round-robin (RR=1) or fixed priority with master 0 highest (RR=0).
//   WAIT_STATES (0..15) inserts extra data-phase cycles per transfer for
//   slower ROMs.
//
// Ports:
//   HCLK       in   1   bus clock
//   HRESET     in   1   synchronous active-high reset
//   HSEL0      in   1   master 0 slave select
//   HTRANS0    in   2   master 0 transfer type (bit 1 set = NONSEQ/SEQ)
//   HADDR0     in  32   master 0 address
//   HREADY0    out  1   master 0 transfer done / accept next address
//   HRDATA0    out 32   master 0 read data (0 unless completing)
//   HSEL1, HTRANS1, HADDR1, HREADY1, HRDATA1: same, for master 1
//   S_HSEL     out  1   ROM select, high while a grant is active
//   S_HADDR    out 32   captured address of the granted master (0 if idle)
//   S_HRDATA   in  32   ROM read data, combinational from S_HADDR
// ---------------------------------------------------------------------------
module ahb_rom_arbiter #(
  parameter bit          RR          = 1'b1,
  parameter int unsigned WAIT_STATES = 32'd0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL0,
  input  logic [1:0]  HTRANS0,
  input  logic [31:0] HADDR0,
  output logic        HREADY0,
  output logic [31:0] HRDATA0,
  input  logic        HSEL1,
  input  logic [1:0]  HTRANS1,
  input  logic [31:0] HADDR1,
  output logic        HREADY1,
  output logic [31:0] HRDATA1,
  output logic        S_HSEL,
  output logic [31:0] S_HADDR,
  input  logic [31:0] S_HRDATA
);

  // Wait-state reload value and the zero-wait shortcut (transfer completes
  // in the grant cycle itself, so the FSM never leaves ARB).
  localparam logic [3:0] LP_WS      = 4'(WAIT_STATES);
  localparam bit         LP_ZERO_WS = (WAIT_STATES == 32'd0);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Request capture registers
  logic        r_pend0;
  logic        r_pend1;
  logic [31:0] r_addr0;
  logic [31:0] r_addr1;

  // Arbiter registers
  state_t      r_state;
  logic        r_owner;
  logic [3:0]  r_cnt;
  logic        r_last;

  // Next-state values
  state_t      w_state_nxt;
  logic        w_owner_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_last_nxt;

  // Grant / completion decode
  logic        w_gnt_vld;
  logic        w_gnt;
  logic        w_done;
  logic        w_done0;
  logic        w_done1;
  logic        w_cap0;
  logic        w_cap1;

  // HTRANS bit 0 only distinguishes NONSEQ/SEQ and BUSY/IDLE pairs, which
  // this slave treats identically.
  logic        w_unused;
  assign w_unused = ^{HTRANS0[0], HTRANS1[0]};

  // Arbitration and transfer sequencing: grant selection, completion and
  // FSM next state.
  always_comb begin
    w_gnt_vld   = 1'b0;
    w_gnt       = 1'b0;
    w_done      = 1'b0;
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      ST_ARB: begin
        w_gnt_vld = r_pend0 | r_pend1;
        if (r_pend0 && r_pend1) begin
          // Tie: round-robin favours whoever did not win last time;
          // fixed priority always picks master 0.
          w_gnt = RR ? ~r_last : 1'b0;
        end else begin
          w_gnt = r_pend1;
        end
        if (w_gnt_vld) begin
          w_last_nxt = w_gnt;
          if (LP_ZERO_WS) begin
            w_done = 1'b1;
          end else begin
            w_state_nxt = ST_XFER;
            w_owner_nxt = w_gnt;
            w_cnt_nxt   = LP_WS;
          end
        end else begin
          w_done = 1'b0;
        end
      end
      ST_XFER: begin
        // Owner is locked for the whole transfer; no re-arbitration.
        w_gnt_vld = 1'b1;
        w_gnt     = r_owner;
        if (r_cnt == 4'd1) begin
          w_done      = 1'b1;
          w_state_nxt = ST_ARB;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign w_done0 = w_done & ~w_gnt;
  assign w_done1 = w_done &  w_gnt;

  // A master is ready when it has nothing outstanding or its transfer is
  // finishing now; that also opens the window for its next address phase.
  assign HREADY0 = ~r_pend0 | w_done0;
  assign HREADY1 = ~r_pend1 | w_done1;
  assign HRDATA0 = w_done0 ? S_HRDATA : 32'd0;
  assign HRDATA1 = w_done1 ? S_HRDATA : 32'd0;

  assign S_HSEL  = w_gnt_vld;
  assign S_HADDR = w_gnt_vld ? (w_gnt ? r_addr1 : r_addr0) : 32'd0;

  // Valid address phase accepted this cycle
  assign w_cap0 = HSEL0 & HTRANS0[1] & HREADY0;
  assign w_cap1 = HSEL1 & HTRANS1[1] & HREADY1;

  // Master 0 request register: capture wins over clear so a completing
  // master can issue back-to-back without a bubble.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pend0 <= 1'b0;
      r_addr0 <= 32'd0;
    end else if (w_cap0) begin
      r_pend0 <= 1'b1;
      r_addr0 <= HADDR0;
    end else if (w_done0) begin
      r_pend0 <= 1'b0;
    end
  end

  // Master 1 request register, same rules as master 0.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pend1 <= 1'b0;
      r_addr1 <= 32'd0;
    end else if (w_cap1) begin
      r_pend1 <= 1'b1;
      r_addr1 <= HADDR1;
    end else if (w_done1) begin
      r_pend1 <= 1'b0;
    end
  end

  // Arbiter state register. last resets to 1 so master 0 wins the first tie;
  // reset mid-transfer simply drops the transfer.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= ST_ARB;
      r_owner <= 1'b0;
      r_cnt   <= 4'd0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_rom_arbiter
//
// Four arbiter instances (RR/WAIT_STATES = 1/0, 0/0, 1/2, 1/3) share one set
// of master stimulus. A transaction-level reference model per instance tracks
// pending requests and a "slave busy until cycle X" timestamp; expected read
// data is queued when an address phase is accepted and popped by a separate
// monitor whenever a master's HREADY shows completion.
// ---------------------------------------------------------------------------
module tb_ahb_rom_arbiter;

  localparam int          NI       = 4;
  localparam bit          RR_T [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int          WS_T [NI] = '{0, 0, 2, 3};
  localparam logic [31:0] ROM_MASK = 32'hFFFF0000;
  localparam logic [1:0]  NONSEQ   = 2'b10;
  localparam logic [1:0]  IDLE     = 2'b00;

  logic        HCLK;
  logic        hreset;
  logic        hsel0, hsel1;
  logic [1:0]  htrans0, htrans1;
  logic [31:0] haddr0, haddr1;

  logic        o_hready [NI][2];
  logic [31:0] o_hrdata [NI][2];
  logic        o_shsel  [NI];
  logic [31:0] o_shaddr [NI];
  logic [31:0] s_hrdata [NI];

  int n_vec;
  int n_err;
  bit mon_en;

  // Scoreboard: expected read data per instance and master, in order
  logic [31:0] sb_q [NI][2][$];

  // Reference model state
  int unsigned cyc;
  bit          m_pend    [NI][2];
  logic [31:0] m_addr    [NI][2];
  bit          m_busy    [NI];
  bit          m_owner   [NI];
  int unsigned m_done_at [NI];
  bit          m_last    [NI];

  logic [31:0] mon_exp;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ahb_rom_arbiter #(.RR(RR_T[g]), .WAIT_STATES(WS_T[g])) u_dut (
      .HCLK     (HCLK),
      .HRESET   (hreset),
      .HSEL0    (hsel0),
      .HTRANS0  (htrans0),
      .HADDR0   (haddr0),
      .HREADY0  (o_hready[g][0]),
      .HRDATA0  (o_hrdata[g][0]),
      .HSEL1    (hsel1),
      .HTRANS1  (htrans1),
      .HADDR1   (haddr1),
      .HREADY1  (o_hready[g][1]),
      .HRDATA1  (o_hrdata[g][1]),
      .S_HSEL   (o_shsel[g]),
      .S_HADDR  (o_shaddr[g]),
      .S_HRDATA (s_hrdata[g])
    );
    // ROM model
    assign s_hrdata[g] = o_shaddr[g] ^ ROM_MASK;
  end

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin
      m_busy[g]    = 1'b0;
      m_owner[g]   = 1'b0;
      m_done_at[g] = 0;
      m_last[g]    = 1'b1;
      for (int m = 0; m < 2; m++) begin
        m_pend[g][m] = 1'b0;
        m_addr[g][m] = 32'd0;
      end
    end
  endtask

  // One bus cycle: entered at negedge+1 with this cycle's outputs stable.
  task automatic step(input bit s0, input logic [1:0] t0, input logic [31:0] a0,
                      input bit s1, input logic [1:0] t1, input logic [31:0] a1,
                      input bit rst);
    bit          gv   [NI];
    bit          gnt  [NI];
    bit          done [NI];
    bit          rdy  [NI][2];
    bit          cap  [NI][2];
    bit          req  [2];
    logic [31:0] adr  [2];
    for (int g = 0; g < NI; g++) begin
      if (m_busy[g]) begin
        gv[g]   = 1'b1;
        gnt[g]  = m_owner[g];
        done[g] = (cyc == m_done_at[g]);
      end else begin
        gv[g] = m_pend[g][0] | m_pend[g][1];
        if (m_pend[g][0] && m_pend[g][1]) gnt[g] = RR_T[g] ? !m_last[g] : 1'b0;
        else gnt[g] = m_pend[g][1];
        done[g] = gv[g] && (WS_T[g] == 0);
      end
      for (int m = 0; m < 2; m++) begin
        rdy[g][m] = !m_pend[g][m] || (done[g] && (int'(gnt[g]) == m));
        chk($sformatf("hready%0d[i%0d]", m, g), {31'd0, o_hready[g][m]}, {31'd0, rdy[g][m]});
      end
      chk($sformatf("s_hsel[i%0d]", g), {31'd0, o_shsel[g]}, {31'd0, gv[g]});
      chk($sformatf("s_haddr[i%0d]", g), o_shaddr[g], gv[g] ? m_addr[g][gnt[g]] : 32'd0);
    end
    hsel0 = s0; htrans0 = t0; haddr0 = a0;
    hsel1 = s1; htrans1 = t1; haddr1 = a1;
    hreset = rst;
    req[0] = s0 && t0[1]; adr[0] = a0;
    req[1] = s1 && t1[1]; adr[1] = a1;
    for (int g = 0; g < NI; g++) begin
      for (int m = 0; m < 2; m++) begin
        if (rst) sb_q[g][m].delete();
        cap[g][m] = !rst && req[m] && rdy[g][m];
        if (cap[g][m]) sb_q[g][m].push_back(adr[m] ^ ROM_MASK);
      end
    end
    @(posedge HCLK);
    if (rst) begin
      model_reset();
    end else begin
      for (int g = 0; g < NI; g++) begin
        for (int m = 0; m < 2; m++) begin
          if (cap[g][m]) begin
            m_pend[g][m] = 1'b1;
            m_addr[g][m] = adr[m];
          end else if (done[g] && (int'(gnt[g]) == m)) begin
            m_pend[g][m] = 1'b0;
          end
        end
        if (!m_busy[g] && gv[g]) begin
          m_last[g] = gnt[g];
          if (WS_T[g] > 0) begin
            m_busy[g]    = 1'b1;
            m_owner[g]   = gnt[g];
            m_done_at[g] = cyc + WS_T[g];
          end
        end else if (m_busy[g] && done[g]) begin
          m_busy[g] = 1'b0;
        end
      end
    end
    cyc++;
    @(negedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, IDLE, 32'd0, 1'b0, IDLE, 32'd0, 1'b0);
  endtask

  // Monitor: on every cycle, a master showing HREADY with an outstanding
  // request must return the queued data; otherwise HRDATA must be zero.
  always @(negedge HCLK) begin
    if (mon_en) begin
      for (int g = 0; g < NI; g++) begin
        for (int m = 0; m < 2; m++) begin
          if (o_hready[g][m] === 1'b1 && sb_q[g][m].size() > 0) begin
            mon_exp = sb_q[g][m].pop_front();
            chk($sformatf("hrdata%0d[i%0d]", m, g), o_hrdata[g][m], mon_exp);
          end else begin
            chk($sformatf("hrdata%0d_quiet[i%0d]", m, g), o_hrdata[g][m], 32'd0);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit          r_s0, r_s1, r_rst;
    logic [1:0]  r_t0, r_t1;
    logic [31:0] r_a0, r_a1;
    n_vec = 0; n_err = 0; mon_en = 1'b0; cyc = 0;
    hreset = 1'b1;
    hsel0 = 1'b0; htrans0 = IDLE; haddr0 = 32'd0;
    hsel1 = 1'b0; htrans1 = IDLE; haddr1 = 32'd0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    #1;
    hreset = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Reset state
    chk("rst_hready0", {31'd0, o_hready[0][0]}, 32'd1);
    chk("rst_hready1", {31'd0, o_hready[0][1]}, 32'd1);
    chk("rst_shsel",   {31'd0, o_shsel[0]}, 32'd0);
    chk("rst_shaddr",  o_shaddr[3], 32'd0);

    // Single uncontended read, zero wait states
    step(1'b1, NONSEQ, 32'h4, 1'b0, IDLE, 32'd0, 1'b0);
    chk("single_shaddr",  o_shaddr[0], 32'h4);
    chk("single_hready0", {31'd0, o_hready[0][0]}, 32'd1);
    chk("single_hrdata0", o_hrdata[0][0], 32'hFFFF0004);
    chk("single_hready1", {31'd0, o_hready[0][1]}, 32'd1);
    chk("single_hrdata1", o_hrdata[0][1], 32'd0);
    idle(5);

    // Simultaneous requests straight after reset: master 0 first
    step(1'b0, IDLE, 32'd0, 1'b0, IDLE, 32'd0, 1'b1);
    step(1'b1, NONSEQ, 32'h8, 1'b1, NONSEQ, 32'hC, 1'b0);
    for (int g = 0; g < 2; g++) begin
      chk("tie_hrdata0", o_hrdata[g][0], 32'hFFFF0008);
      chk("tie_hready1", {31'd0, o_hready[g][1]}, 32'd0);
    end
    idle(1);
    for (int g = 0; g < 2; g++) begin
      chk("tie_hrdata1", o_hrdata[g][1], 32'hFFFF000C);
      chk("tie_hready1b", {31'd0, o_hready[g][1]}, 32'd1);
    end
    idle(8);

    // Both masters requesting continuously, then master 0 goes idle
    for (int k = 0; k < 10; k++)
      step(1'b1, NONSEQ, 32'h100 + 32'(4 * k), 1'b1, NONSEQ, 32'h200 + 32'(4 * k), 1'b0);
    for (int k = 0; k < 4; k++)
      step(1'b0, IDLE, 32'd0, 1'b1, NONSEQ, 32'h300 + 32'(4 * k), 1'b0);
    idle(10);

    // Two wait states, master 1
    step(1'b0, IDLE, 32'd0, 1'b1, NONSEQ, 32'h10, 1'b0);
    chk("ws2_hready1_n1", {31'd0, o_hready[2][1]}, 32'd0);
    chk("ws2_shaddr_n1",  o_shaddr[2], 32'h10);
    idle(1);
    chk("ws2_hready1_n2", {31'd0, o_hready[2][1]}, 32'd0);
    chk("ws2_shaddr_n2",  o_shaddr[2], 32'h10);
    idle(1);
    chk("ws2_hready1_n3", {31'd0, o_hready[2][1]}, 32'd1);
    chk("ws2_hrdata1_n3", o_hrdata[2][1], 32'hFFFF0010);
    idle(6);

    // Three wait states, reset in the middle of a transfer
    step(1'b1, NONSEQ, 32'h20, 1'b0, IDLE, 32'd0, 1'b0);
    idle(1);
    step(1'b0, IDLE, 32'd0, 1'b0, IDLE, 32'd0, 1'b1);
    chk("ws3_rst_hready0", {31'd0, o_hready[3][0]}, 32'd1);
    chk("ws3_rst_hready1", {31'd0, o_hready[3][1]}, 32'd1);
    chk("ws3_rst_shsel",   {31'd0, o_shsel[3]}, 32'd0);
    step(1'b1, NONSEQ, 32'h24, 1'b0, IDLE, 32'd0, 1'b0);
    idle(2);
    chk("ws3_hready0_m3", {31'd0, o_hready[3][0]}, 32'd0);
    idle(1);
    chk("ws3_hready0_m4", {31'd0, o_hready[3][0]}, 32'd1);
    chk("ws3_hrdata0_m4", o_hrdata[3][0], 32'hFFFF0024);
    idle(4);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      r_s0  = ($urandom_range(0, 3) != 0);
      r_s1  = ($urandom_range(0, 3) != 0);
      r_t0  = 2'($urandom_range(0, 3));
      r_t1  = 2'($urandom_range(0, 3));
      r_a0  = $urandom;
      r_a1  = $urandom;
      r_rst = ($urandom_range(0, 149) == 0);
      step(r_s0, r_t0, r_a0, r_s1, r_t1, r_a1, r_rst);
    end

    // Drain: every accepted request must have been answered
    idle(40);
    for (int g = 0; g < NI; g++)
      for (int m = 0; m < 2; m++)
        chk($sformatf("drain%0d[i%0d]", m, g), 32'(sb_q[g][m].size()), 32'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
